// File: rtl/mem_arbiter.sv
// Two-master (fetch / data) arbiter that feeds one AXI controller request channel.
// Latency: 1 cycle from request to ctl_* valid; back-to-back grants add no idle cycle.
// Backpressure: the owner holds until ctl_ready & x_done. The other master waits with ready=0.
//
// Ports:
//   CLK, nRST                  clock, asynchronous active-low reset
//   i_read/i_addr/i_done       fetch request, address, fetch-stage consume
//   i_ready/i_load             fetch complete, fetched word
//   d_read/d_write/d_addr      data request (write size 0..3 wins over read), address
//   d_store/d_done             store data, mem-stage consume
//   d_ready/d_load             data access complete, loaded word
//   ctl_read/ctl_write         latched operation towards the controller
//   ctl_addr/ctl_store         latched address and store data
//   ctl_done                   transaction acknowledged to the controller
//   ctl_ready/ctl_load         controller access done, load data
module mem_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        i_read,
  input  logic [31:0] i_addr,
  input  logic        i_done,
  output logic        i_ready,
  output logic [31:0] i_load,
  input  logic        d_read,
  input  logic [1:0]  d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_store,
  input  logic        d_done,
  output logic        d_ready,
  output logic [31:0] d_load,
  output logic        ctl_read,
  output logic [1:0]  ctl_write,
  output logic [31:0] ctl_addr,
  output logic [31:0] ctl_store,
  output logic        ctl_done,
  input  logic        ctl_ready,
  input  logic [31:0] ctl_load
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DRAIN} state_t;

  state_t      state_q, state_d;
  logic        last_d_q, last_d_d;       // 1: data port held the most recent grant
  logic        drain_own_q, drain_own_d; // owner of the abandoned transaction (1 = data)
  logic        op_read_q, op_read_d;
  logic [1:0]  op_write_q, op_write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;

  logic ireq, dreq;
  logic grant_i, grant_d;

  assign ireq = i_read;
  assign dreq = d_read | (d_write != 2'b00);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      last_d_q    <= ~DATA_FIRST;
      drain_own_q <= 1'b0;
      op_read_q   <= 1'b0;
      op_write_q  <= 2'b00;
      addr_q      <= 32'h0;
      store_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      drain_own_q <= drain_own_d;
      op_read_q   <= op_read_d;
      op_write_q  <= op_write_d;
      addr_q      <= addr_d;
      store_q     <= store_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    drain_own_d = drain_own_q;
    op_read_d   = op_read_q;
    op_write_d  = op_write_q;
    addr_d      = addr_q;
    store_d     = store_q;
    grant_i     = 1'b0;
    grant_d     = 1'b0;

    // Address/store always come from the latch so they never glitch with master inputs.
    ctl_read  = 1'b0;
    ctl_write = 2'b00;
    ctl_addr  = addr_q;
    ctl_store = store_q;
    ctl_done  = 1'b0;
    i_ready   = 1'b0;
    i_load    = 32'h0;
    d_ready   = 1'b0;
    d_load    = 32'h0;

    case (state_q)
      IDLE: begin
        if (ireq && dreq) begin
          // Tie: the master that did not win last time goes first.
          if (last_d_q) grant_i = 1'b1;
          else          grant_d = 1'b1;
        end else if (ireq) begin
          grant_i = 1'b1;
        end else if (dreq) begin
          grant_d = 1'b1;
        end
      end

      GNT_I: begin
        ctl_read  = op_read_q;
        ctl_write = op_write_q;
        i_ready   = ctl_ready;
        i_load    = ctl_load;
        ctl_done  = i_done;
        if (ctl_ready && i_done) begin
          // The fetch request is stale on its own completion edge, so only data may follow.
          if (dreq) grant_d = 1'b1;
          else      state_d = IDLE;
        end else if (!ireq) begin
          if (ctl_ready) begin
            ctl_done = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d     = DRAIN;
            drain_own_d = 1'b0;
          end
        end
      end

      GNT_D: begin
        ctl_read  = op_read_q;
        ctl_write = op_write_q;
        d_ready   = ctl_ready;
        d_load    = ctl_load;
        ctl_done  = d_done;
        if (ctl_ready && d_done) begin
          if (ireq) grant_i = 1'b1;
          else      state_d = IDLE;
        end else if (!dreq) begin
          if (ctl_ready) begin
            ctl_done = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d     = DRAIN;
            drain_own_d = 1'b1;
          end
        end
      end

      DRAIN: begin
        // Nobody consumes the result; acknowledge it ourselves as soon as it arrives.
        ctl_read  = op_read_q;
        ctl_write = op_write_q;
        ctl_done  = ctl_ready;
        if (ctl_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (grant_i) begin
      state_d    = GNT_I;
      last_d_d   = 1'b0;
      op_read_d  = 1'b1;
      op_write_d = 2'b00;
      addr_d     = i_addr;
      store_d    = 32'h0;
    end

    if (grant_d) begin
      state_d    = GNT_D;
      last_d_d   = 1'b1;
      // A simultaneous read and write is treated as the write.
      op_read_d  = (d_write == 2'b00);
      op_write_d = d_write;
      addr_d     = d_addr;
      store_d    = d_store;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        i_read = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic        i_done = 1'b0;
  logic        d_read = 1'b0;
  logic [1:0]  d_write = 2'b00;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_store = 32'h0;
  logic        d_done = 1'b0;
  logic        ctl_ready = 1'b0;
  logic [31:0] ctl_load = 32'h0;

  logic        i_ready, d_ready, ctl_read, ctl_done;
  logic [31:0] i_load, d_load, ctl_addr, ctl_store;
  logic [1:0]  ctl_write;

  mem_arbiter #(.DATA_FIRST(1'b1)) dut (
    .CLK(CLK), .nRST(nRST),
    .i_read(i_read), .i_addr(i_addr), .i_done(i_done),
    .i_ready(i_ready), .i_load(i_load),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_store(d_store),
    .d_done(d_done), .d_ready(d_ready), .d_load(d_load),
    .ctl_read(ctl_read), .ctl_write(ctl_write), .ctl_addr(ctl_addr),
    .ctl_store(ctl_store), .ctl_done(ctl_done),
    .ctl_ready(ctl_ready), .ctl_load(ctl_load)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  // Transaction-level model: who owns the channel (0 none, 1 fetch, 2 data, 3 draining),
  // who wins the next tie, and the operation captured at grant time.
  int          m_own;
  bit          m_data_wins;
  bit          m_rd;
  logic [1:0]  m_wr;
  logic [31:0] m_addr, m_st;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own       = 0;
    m_data_wins = 1'b1;
    m_rd        = 1'b0;
    m_wr        = 2'b00;
    m_addr      = 32'h0;
    m_st        = 32'h0;
  endtask

  task automatic model_grant(input int who);
    m_own       = who;
    m_data_wins = (who == 1);
    if (who == 1) begin
      m_rd = 1'b1; m_wr = 2'b00; m_addr = i_addr; m_st = 32'h0;
    end else begin
      m_rd = (d_write == 2'b00); m_wr = d_write; m_addr = d_addr; m_st = d_store;
    end
  endtask

  // Check every output against the model for the current cycle, then advance the model
  // to what the next rising edge must produce.
  task automatic model_step();
    bit          iq, dq;
    logic        e_cr, e_cd, e_ir, e_dr;
    logic [1:0]  e_cw;
    logic [31:0] e_il, e_dl;
    if (!nRST) begin
      model_reset();
      return;
    end
    iq = i_read;
    dq = d_read || (d_write != 2'b00);
    e_cr = 1'b0; e_cw = 2'b00; e_cd = 1'b0;
    e_ir = 1'b0; e_dr = 1'b0; e_il = 32'h0; e_dl = 32'h0;
    case (m_own)
      1: begin
        e_cr = m_rd; e_cw = m_wr; e_ir = ctl_ready; e_il = ctl_load;
        e_cd = i_done | (ctl_ready & !iq);
      end
      2: begin
        e_cr = m_rd; e_cw = m_wr; e_dr = ctl_ready; e_dl = ctl_load;
        e_cd = d_done | (ctl_ready & !dq);
      end
      3: begin
        e_cr = m_rd; e_cw = m_wr; e_cd = ctl_ready;
      end
      default: ;
    endcase
    chk("ctl_read",  32'(ctl_read),  32'(e_cr));
    chk("ctl_write", 32'(ctl_write), 32'(e_cw));
    chk("ctl_done",  32'(ctl_done),  32'(e_cd));
    chk("i_ready",   32'(i_ready),   32'(e_ir));
    chk("d_ready",   32'(d_ready),   32'(e_dr));
    chk("i_load",    i_load, e_il);
    chk("d_load",    d_load, e_dl);
    if (m_own != 0) begin
      chk("ctl_addr",  ctl_addr,  m_addr);
      chk("ctl_store", ctl_store, m_st);
    end
    case (m_own)
      0: begin
        if (iq && dq)  model_grant(m_data_wins ? 2 : 1);
        else if (iq)   model_grant(1);
        else if (dq)   model_grant(2);
      end
      1: begin
        if (ctl_ready && i_done) begin
          if (dq) model_grant(2); else m_own = 0;
        end else if (!iq) m_own = ctl_ready ? 0 : 3;
      end
      2: begin
        if (ctl_ready && d_done) begin
          if (iq) model_grant(1); else m_own = 0;
        end else if (!dq) m_own = ctl_ready ? 0 : 3;
      end
      default: if (ctl_ready) m_own = 0;
    endcase
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic go();
    @(negedge CLK);
    model_step();
  endtask

  task automatic clear_in();
    i_read = 1'b0; i_addr = 32'h0; i_done = 1'b0;
    d_read = 1'b0; d_write = 2'b00; d_addr = 32'h0; d_store = 32'h0; d_done = 1'b0;
    ctl_ready = 1'b0; ctl_load = 32'h0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ctl_read"},  32'(ctl_read),  32'h0);
    chk({tag, " ctl_write"}, 32'(ctl_write), 32'h0);
    chk({tag, " ctl_addr"},  ctl_addr,  32'h0);
    chk({tag, " ctl_store"}, ctl_store, 32'h0);
    chk({tag, " ctl_done"},  32'(ctl_done),  32'h0);
    chk({tag, " i_ready"},   32'(i_ready),   32'h0);
    chk({tag, " i_load"},    i_load,    32'h0);
    chk({tag, " d_ready"},   32'(d_ready),   32'h0);
    chk({tag, " d_load"},    d_load,    32'h0);
  endtask

  task automatic do_reset();
    tick();
    nRST = 1'b0;
    clear_in();
    #1;
    model_reset();
    tick();
    tick();
    nRST = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_a;
    // Power-up: a real falling edge on nRST before any clock edge.
    #2 nRST = 1'b0;
    #1;
    chk_all_zero("por");
    model_reset();
    tick();
    tick();
    nRST = 1'b1;

    // Single fetch
    tick(); i_read = 1'b1; i_addr = 32'h100; go();
    chk("fetch idle ctl_read", 32'(ctl_read), 32'h0);
    tick(); go();
    chk("fetch ctl_read", 32'(ctl_read), 32'h1);
    chk("fetch ctl_addr", ctl_addr, 32'h100);
    tick(); ctl_ready = 1'b1; ctl_load = 32'hDEADBEEF; go();
    chk("fetch i_ready", 32'(i_ready), 32'h1);
    chk("fetch i_load", i_load, 32'hDEADBEEF);
    chk("fetch stall ctl_done", 32'(ctl_done), 32'h0);
    tick(); i_done = 1'b1; go();
    chk("fetch ctl_done", 32'(ctl_done), 32'h1);
    tick(); clear_in(); go();
    chk("fetch back idle", 32'(ctl_read), 32'h0);

    // Tie after reset: data first, then fetch with no idle cycle
    do_reset();
    tick(); i_read = 1'b1; i_addr = 32'h100;
    d_write = 2'd3; d_addr = 32'h200; d_store = 32'h12345678; go();
    tick(); go();
    chk("tie ctl_write", 32'(ctl_write), 32'h3);
    chk("tie ctl_store", ctl_store, 32'h12345678);
    chk("tie ctl_read", 32'(ctl_read), 32'h0);
    tick(); ctl_ready = 1'b1; d_done = 1'b1; go();
    chk("tie d_ready", 32'(d_ready), 32'h1);
    chk("tie i_ready", 32'(i_ready), 32'h0);
    tick(); d_write = 2'd0; d_done = 1'b0; ctl_ready = 1'b0; i_addr = 32'h104; go();
    chk("tie next ctl_read", 32'(ctl_read), 32'h1);
    chk("tie next ctl_addr", ctl_addr, 32'h100);
    tick(); ctl_ready = 1'b1; ctl_load = 32'hCAFE0001; i_done = 1'b1; go();
    chk("tie i_load", i_load, 32'hCAFE0001);
    tick(); clear_in(); go();

    // Round-robin: D, I, D, I, D, I
    tick(); i_read = 1'b1; i_addr = 32'h1000; d_read = 1'b1; d_addr = 32'h2000; go();
    for (int k = 0; k < 6; k++) begin
      exp_a = (k % 2 == 0) ? 32'h2000 : 32'h1000;
      tick(); ctl_ready = 1'b0; i_done = 1'b0; d_done = 1'b0; go();
      chk("rr stall addr", ctl_addr, exp_a);
      tick(); ctl_ready = 1'b1; ctl_load = 32'(k); i_done = 1'b1; d_done = 1'b1;
      if (k == 5) d_read = 1'b0;
      go();
      chk("rr owner addr", ctl_addr, exp_a);
      chk("rr i_ready", 32'(i_ready), (k % 2 == 1) ? 32'h1 : 32'h0);
      chk("rr d_ready", 32'(d_ready), (k % 2 == 0) ? 32'h1 : 32'h0);
    end
    tick(); clear_in(); go();

    // Operand stability
    tick(); d_read = 1'b1; d_addr = 32'h200; go();
    tick(); d_addr = 32'h300; go();
    chk("stable addr 1", ctl_addr, 32'h200);
    tick(); go();
    chk("stable addr 2", ctl_addr, 32'h200);
    tick(); ctl_ready = 1'b1; ctl_load = 32'h55AA55AA; d_done = 1'b1; go();
    chk("stable addr done", ctl_addr, 32'h200);
    chk("stable d_load", d_load, 32'h55AA55AA);
    tick(); clear_in(); go();

    // Abandon and drain
    tick(); i_read = 1'b1; i_addr = 32'h400; go();
    tick(); go();
    chk("abandon owner addr", ctl_addr, 32'h400);
    tick(); i_read = 1'b0; d_read = 1'b1; d_addr = 32'h500; go();
    chk("abandon i_ready", 32'(i_ready), 32'h0);
    chk("abandon ctl_done", 32'(ctl_done), 32'h0);
    tick(); go();
    chk("drain ctl_read", 32'(ctl_read), 32'h1);
    chk("drain ctl_done wait", 32'(ctl_done), 32'h0);
    tick(); ctl_ready = 1'b1; ctl_load = 32'h77; go();
    chk("drain ctl_done", 32'(ctl_done), 32'h1);
    chk("drain i_ready", 32'(i_ready), 32'h0);
    chk("drain d_ready", 32'(d_ready), 32'h0);
    tick(); ctl_ready = 1'b0; go();
    chk("post drain idle", 32'(ctl_read), 32'h0);
    tick(); go();
    chk("post drain d addr", ctl_addr, 32'h500);
    tick(); ctl_ready = 1'b1; d_done = 1'b1; go();
    tick(); clear_in(); go();

    // Asynchronous reset in the middle of a data grant
    tick(); d_write = 2'd2; d_addr = 32'h600; d_store = 32'hAAAA; go();
    tick(); ctl_ready = 1'b1; ctl_load = 32'h99; go();
    chk("pre reset ctl_write", 32'(ctl_write), 32'h2);
    chk("pre reset d_ready", 32'(d_ready), 32'h1);
    #2 nRST = 1'b0;
    #1;
    chk_all_zero("mid reset");
    model_reset();
    tick();
    tick(); nRST = 1'b1; clear_in();
    i_read = 1'b1; i_addr = 32'h700; d_read = 1'b1; d_addr = 32'h800; go();
    tick(); go();
    chk("reset tie data first", ctl_addr, 32'h800);
    tick(); ctl_ready = 1'b1; d_done = 1'b1; go();
    tick(); d_read = 1'b0; d_done = 1'b0; ctl_ready = 1'b0; go();
    chk("reset tie then fetch", ctl_addr, 32'h700);
    tick(); ctl_ready = 1'b1; i_done = 1'b1; go();
    tick(); clear_in(); go();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
